// File: rtl/db_pkg.sv
// Shared types and constants for the debugger core-side sequencer.
package db_pkg;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_PAUSE,
        CMD_RESUME,
        CMD_RESET,
        CMD_REG_RD,
        CMD_REG_WR,
        CMD_MEM_RD,
        CMD_MEM_WR
    } cmd_t;

    typedef enum logic [2:0] {
        StIdle,
        StExec,
        StMemWait,
        StHaltWait,
        StRstHold
    } seq_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/db_cmd_sequencer_if.sv
// Command bus between mcu_controller (master) and the core-side sequencer (slave).
interface db_cmd_sequencer_if;
    logic        valid;
    logic        pause;
    logic        resume;
    logic        reset;
    logic        reg_rd;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_be;
    logic [31:0] addr;
    logic [31:0] d_in;
    logic        busy;
    logic [31:0] d_rd;
    logic        error;

    modport master (
        output valid, pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr, mem_be, addr, d_in,
        input  busy, d_rd, error
    );

    modport slave (
        input  valid, pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr, mem_be, addr, d_in,
        output busy, d_rd, error
    );
endinterface

// File: rtl/db_cmd_decode.sv
// Maps the raw command flags to a single command; zero or several flags is illegal.
module db_cmd_decode
    import db_pkg::*;
(
    input  logic pause_i,
    input  logic resume_i,
    input  logic reset_i,
    input  logic reg_rd_i,
    input  logic reg_wr_i,
    input  logic mem_rd_i,
    input  logic mem_wr_i,
    output cmd_t cmd_o,
    output logic illegal_o
);

    logic [6:0] flags;
    assign flags = {mem_wr_i, mem_rd_i, reg_wr_i, reg_rd_i, reset_i, resume_i, pause_i};

    always_comb begin
        cmd_o     = CMD_NONE;
        illegal_o = 1'b0;
        case (flags)
            7'b000_0001: cmd_o = CMD_PAUSE;
            7'b000_0010: cmd_o = CMD_RESUME;
            7'b000_0100: cmd_o = CMD_RESET;
            7'b000_1000: cmd_o = CMD_REG_RD;
            7'b001_0000: cmd_o = CMD_REG_WR;
            7'b010_0000: cmd_o = CMD_MEM_RD;
            7'b100_0000: cmd_o = CMD_MEM_WR;
            default:     illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/db_cmd_sequencer.sv
// Runs debugger commands against the core: halt/resume, timed core reset,
// register-file and data-memory accesses.
module db_cmd_sequencer
    import db_pkg::*;
#(
    parameter int unsigned MEM_LAT      = 1,
    parameter int unsigned RST_CYCLES   = 4,
    parameter int unsigned HALT_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    db_cmd_sequencer_if.slave   cmd_if,
    input  logic [31:0]         pc_i,
    output logic                core_halt_o,
    input  logic                core_halted_i,
    output logic                core_rst_o,
    output logic [4:0]          rf_addr_o,
    output logic [31:0]         rf_wd_o,
    output logic                rf_we_o,
    input  logic [31:0]         rf_rd_i,
    output logic [31:0]         mem_addr_o,
    output logic [31:0]         mem_wd_o,
    output logic                mem_we_o,
    output logic                mem_re_o,
    output logic [1:0]          mem_size_o,
    input  logic [31:0]         mem_rdata_i
);

    localparam int unsigned CntMax =
        (HALT_TIMEOUT > RST_CYCLES) ? ((HALT_TIMEOUT > MEM_LAT) ? HALT_TIMEOUT : MEM_LAT)
                                    : ((RST_CYCLES > MEM_LAT) ? RST_CYCLES : MEM_LAT);
    localparam int unsigned CntW = $clog2(CntMax + 1);

    seq_state_t        state_q;
    cmd_t              cmd_q;
    logic              bad_q;
    logic              be_q;
    logic              paused_q;
    logic              error_q;
    logic [31:0]       d_rd_q;
    logic [CntW-1:0]   cnt_q;
    logic              core_halt_q;
    logic              core_rst_q;
    logic [4:0]        rf_addr_q;
    logic [31:0]       rf_wd_q;
    logic              rf_we_q;
    logic [31:0]       mem_addr_q;
    logic [31:0]       mem_wd_q;
    logic              mem_we_q;
    logic              mem_re_q;
    logic [1:0]        mem_size_q;

    cmd_t        cmd_d;
    logic        illegal;
    logic        is_reg;
    logic        is_mem;
    logic        bad_d;
    logic [1:0]  size_d;
    logic [31:0] wd_d;

    db_cmd_decode u_decode (
        .pause_i   (cmd_if.pause),
        .resume_i  (cmd_if.resume),
        .reset_i   (cmd_if.reset),
        .reg_rd_i  (cmd_if.reg_rd),
        .reg_wr_i  (cmd_if.reg_wr),
        .mem_rd_i  (cmd_if.mem_rd),
        .mem_wr_i  (cmd_if.mem_wr),
        .cmd_o     (cmd_d),
        .illegal_o (illegal)
    );

    // Checks run on the incoming command so the access strobes can be registered
    // at acceptance and appear in the first EXEC cycle.
    assign is_reg = (cmd_d == CMD_REG_RD) || (cmd_d == CMD_REG_WR);
    assign is_mem = (cmd_d == CMD_MEM_RD) || (cmd_d == CMD_MEM_WR);
    assign bad_d  = illegal
                  | ((is_reg | is_mem) & (~paused_q | ~core_halted_i))
                  | (is_reg & (cmd_if.addr[31:5] != 27'd0))
                  | (is_mem & ~cmd_if.mem_be & (cmd_if.addr[1:0] != 2'b00));
    assign size_d = cmd_if.mem_be ? SIZE_BYTE : SIZE_WORD;
    assign wd_d   = cmd_if.mem_be ? {24'd0, cmd_if.d_in[7:0]} : cmd_if.d_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cmd_q       <= CMD_NONE;
            bad_q       <= 1'b0;
            be_q        <= 1'b0;
            paused_q    <= 1'b0;
            error_q     <= 1'b0;
            d_rd_q      <= 32'd0;
            cnt_q       <= '0;
            core_halt_q <= 1'b0;
            core_rst_q  <= 1'b0;
            rf_addr_q   <= 5'd0;
            rf_wd_q     <= 32'd0;
            rf_we_q     <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wd_q    <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_size_q  <= 2'b00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_if.valid) begin
                        cmd_q   <= cmd_d;
                        bad_q   <= bad_d;
                        be_q    <= cmd_if.mem_be;
                        error_q <= 1'b0;
                        state_q <= StExec;
                        if (!bad_d) begin
                            case (cmd_d)
                                CMD_PAUSE: begin
                                    paused_q    <= 1'b1;
                                    core_halt_q <= 1'b1;
                                end
                                CMD_RESUME: begin
                                    paused_q    <= 1'b0;
                                    core_halt_q <= 1'b0;
                                end
                                CMD_RESET:  core_rst_q <= 1'b1;
                                CMD_REG_RD: rf_addr_q  <= cmd_if.addr[4:0];
                                CMD_REG_WR: begin
                                    rf_addr_q <= cmd_if.addr[4:0];
                                    rf_wd_q   <= cmd_if.d_in;
                                    rf_we_q   <= (cmd_if.addr[4:0] != 5'd0);
                                end
                                CMD_MEM_RD: begin
                                    mem_addr_q <= cmd_if.addr;
                                    mem_size_q <= size_d;
                                    mem_re_q   <= 1'b1;
                                end
                                CMD_MEM_WR: begin
                                    mem_addr_q <= cmd_if.addr;
                                    mem_size_q <= size_d;
                                    mem_wd_q   <= wd_d;
                                    mem_we_q   <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                StExec: begin
                    rf_we_q  <= 1'b0;
                    mem_we_q <= 1'b0;
                    mem_re_q <= 1'b0;
                    state_q  <= StIdle;
                    if (bad_q) begin
                        error_q <= 1'b1;
                    end else begin
                        case (cmd_q)
                            CMD_PAUSE: begin
                                cnt_q   <= CntW'(HALT_TIMEOUT - 1);
                                state_q <= StHaltWait;
                            end
                            CMD_RESUME: d_rd_q <= 32'd0;
                            CMD_RESET: begin
                                if (RST_CYCLES > 1) begin
                                    cnt_q   <= CntW'(RST_CYCLES - 2);
                                    state_q <= StRstHold;
                                end else begin
                                    core_rst_q <= 1'b0;
                                end
                            end
                            CMD_REG_RD: d_rd_q <= (rf_addr_q == 5'd0) ? 32'd0 : rf_rd_i;
                            CMD_MEM_RD: begin
                                cnt_q   <= CntW'(MEM_LAT - 1);
                                state_q <= StMemWait;
                            end
                            default: ;
                        endcase
                    end
                end
                StMemWait: begin
                    if (cnt_q == '0) begin
                        d_rd_q  <= be_q ? {24'd0, mem_rdata_i[7:0]} : mem_rdata_i;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StHaltWait: begin
                    // Halted is tested first so it beats a coincident timeout.
                    if (core_halted_i) begin
                        d_rd_q  <= pc_i;
                        state_q <= StIdle;
                    end else if (cnt_q == '0) begin
                        error_q     <= 1'b1;
                        paused_q    <= 1'b0;
                        core_halt_q <= 1'b0;
                        state_q     <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StRstHold: begin
                    if (cnt_q == '0) begin
                        core_rst_q <= 1'b0;
                        state_q    <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Combinational so busy rises in the same cycle as valid.
    assign cmd_if.busy  = (state_q != StIdle) | cmd_if.valid;
    assign cmd_if.d_rd  = d_rd_q;
    assign cmd_if.error = error_q;

    assign core_halt_o = core_halt_q;
    assign core_rst_o  = core_rst_q;
    assign rf_addr_o   = rf_addr_q;
    assign rf_wd_o     = rf_wd_q;
    assign rf_we_o     = rf_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wd_o    = mem_wd_q;
    assign mem_we_o    = mem_we_q;
    assign mem_re_o    = mem_re_q;
    assign mem_size_o  = mem_size_q;

endmodule

// File: tb/tb_db_cmd_sequencer.sv
// Self-checking bench for db_cmd_sequencer: vector table, scoreboard, and corner sequences.
module tb_db_cmd_sequencer;

    localparam int unsigned MemLat  = 3;
    localparam int unsigned RstCyc  = 4;
    localparam int unsigned HaltTo  = 255;
    localparam logic [31:0] Pc      = 32'h8000_0124;

    // Flag order: {mem_wr, mem_rd, reg_wr, reg_rd, reset, resume, pause}
    localparam logic [6:0] FPause  = 7'b000_0001;
    localparam logic [6:0] FResume = 7'b000_0010;
    localparam logic [6:0] FReset  = 7'b000_0100;
    localparam logic [6:0] FRegRd  = 7'b000_1000;
    localparam logic [6:0] FRegWr  = 7'b001_0000;
    localparam logic [6:0] FMemRd  = 7'b010_0000;
    localparam logic [6:0] FMemWr  = 7'b100_0000;

    typedef struct {
        logic [6:0]  flags;
        logic        be;
        logic [31:0] addr;
        logic [31:0] din;
        logic        chk_d;
        logic [31:0] exp_d;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    typedef struct {
        logic        chk_d;
        logic [31:0] exp_d;
        logic        exp_err;
        int          exp_cyc;
        int          tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_halt, core_halted, core_rst;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wd, rf_rd;
    logic        rf_we;
    logic [31:0] mem_addr, mem_wd, mem_rdata;
    logic        mem_we, mem_re;
    logic [1:0]  mem_size;
    logic        stuck;

    int n_cmp = 0;
    int n_fail = 0;
    int rf_we_cnt = 0;
    int mem_we_cnt = 0;
    int core_rst_cnt = 0;
    int hcnt = 0;
    exp_t sb[$];
    vec_t vecs[20];

    db_cmd_sequencer_if cmd_if ();

    db_cmd_sequencer #(
        .MEM_LAT      (MemLat),
        .RST_CYCLES   (RstCyc),
        .HALT_TIMEOUT (HaltTo)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_if        (cmd_if),
        .pc_i          (Pc),
        .core_halt_o   (core_halt),
        .core_halted_i (core_halted),
        .core_rst_o    (core_rst),
        .rf_addr_o     (rf_addr),
        .rf_wd_o       (rf_wd),
        .rf_we_o       (rf_we),
        .rf_rd_i       (rf_rd),
        .mem_addr_o    (mem_addr),
        .mem_wd_o      (mem_wd),
        .mem_we_o      (mem_we),
        .mem_re_o      (mem_re),
        .mem_size_o    (mem_size),
        .mem_rdata_i   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Core: drains 3 cycles after halt is requested unless stuck.
    always @(posedge clk) begin
        if (!core_halt) begin
            hcnt        <= 0;
            core_halted <= 1'b0;
        end else if (!stuck) begin
            if (hcnt == 3) core_halted <= 1'b1;
            else hcnt <= hcnt + 1;
        end
    end

    // Register file; x0 storage holds junk so the sequencer must zero it.
    logic [31:0] rf [32];
    assign rf_rd = rf[rf_addr];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'h5555_5555 : 32'd0;
        end else if (rf_we) begin
            rf[rf_addr] <= rf_wd;
        end
    end

    // Byte-addressed memory; byte reads drive the byte on every lane.
    logic [7:0]  mem_b [512];
    logic [8:0]  ma;
    logic [31:0] rd_val;
    logic [31:0] rpipe [MemLat];
    assign ma = mem_addr[8:0];
    always_comb begin
        if (mem_size == 2'b00) rd_val = {4{mem_b[ma]}};
        else rd_val = {mem_b[ma + 9'd3], mem_b[ma + 9'd2], mem_b[ma + 9'd1], mem_b[ma]};
    end
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 512; i++) mem_b[i] <= 8'h00;
        end else if (mem_we) begin
            if (mem_size == 2'b00) begin
                mem_b[ma] <= mem_wd[7:0];
            end else begin
                mem_b[ma]        <= mem_wd[7:0];
                mem_b[ma + 9'd1] <= mem_wd[15:8];
                mem_b[ma + 9'd2] <= mem_wd[23:16];
                mem_b[ma + 9'd3] <= mem_wd[31:24];
            end
        end
        rpipe[0] <= mem_re ? rd_val : 32'hBAD0_BAD0;
        for (int i = 1; i < MemLat; i++) rpipe[i] <= rpipe[i - 1];
    end
    assign mem_rdata = rpipe[MemLat - 1];

    always @(posedge clk) begin
        if (rf_we) rf_we_cnt <= rf_we_cnt + 1;
        if (mem_we) mem_we_cnt <= mem_we_cnt + 1;
        if (core_rst) core_rst_cnt <= core_rst_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " busy"},      {31'd0, cmd_if.busy},  32'd0);
        check({tag, " error"},     {31'd0, cmd_if.error}, 32'd0);
        check({tag, " d_rd"},      cmd_if.d_rd,           32'd0);
        check({tag, " core_halt"}, {31'd0, core_halt},    32'd0);
        check({tag, " core_rst"},  {31'd0, core_rst},     32'd0);
        check({tag, " rf_we"},     {31'd0, rf_we},        32'd0);
        check({tag, " mem_we"},    {31'd0, mem_we},       32'd0);
        check({tag, " mem_re"},    {31'd0, mem_re},       32'd0);
        check({tag, " rf_addr"},   {27'd0, rf_addr},      32'd0);
        check({tag, " rf_wd"},     rf_wd,                 32'd0);
        check({tag, " mem_addr"},  mem_addr,              32'd0);
        check({tag, " mem_wd"},    mem_wd,                32'd0);
        check({tag, " mem_size"},  {30'd0, mem_size},     32'd0);
    endtask

    task automatic drive(input logic [6:0] f, input logic be, input logic [31:0] a,
                         input logic [31:0] d, input logic v);
        cmd_if.pause  = f[0];
        cmd_if.resume = f[1];
        cmd_if.reset  = f[2];
        cmd_if.reg_rd = f[3];
        cmd_if.reg_wr = f[4];
        cmd_if.mem_rd = f[5];
        cmd_if.mem_wr = f[6];
        cmd_if.mem_be = be;
        cmd_if.addr   = a;
        cmd_if.d_in   = d;
        cmd_if.valid  = v;
    endtask

    task automatic do_cmd(input vec_t v, input int tag);
        exp_t e;
        int cyc;
        sb.push_back('{v.chk_d, v.exp_d, v.exp_err, v.exp_cyc, tag});
        @(posedge clk); #1;
        drive(v.flags, v.be, v.addr, v.din, 1'b1);
        #1;
        check($sformatf("v%0d busy_c0", tag), {31'd0, cmd_if.busy}, 32'd1);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            if (cyc == 0) drive(7'd0, 1'b0, 32'd0, 32'd0, 1'b0);
            cyc++;
        end while (cmd_if.busy && cyc < 400);
        e = sb.pop_front();
        if (cmd_if.busy) begin
            n_cmp++;
            n_fail++;
            $display("FAIL v%0d timeout: busy still 1 after %0d cycles, want 0", e.tag, cyc);
        end else begin
            check($sformatf("v%0d latency", e.tag), 32'(cyc), 32'(e.exp_cyc));
            check($sformatf("v%0d error", e.tag), {31'd0, cmd_if.error}, {31'd0, e.exp_err});
            if (e.chk_d) check($sformatf("v%0d d_rd", e.tag), cmd_if.d_rd, e.exp_d);
        end
    endtask

    initial begin
        int we_before;
        vec_t tv;
        rst_n = 1'b0;
        stuck = 1'b0;
        drive(7'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        rst_n = 1'b1;

        //          flags            be    addr          din           chk   exp_d          err  cyc
        vecs[0]  = '{FMemRd,          1'b0, 32'h40,       32'h0,        1'b0, 32'h0,         1'b1, 2};
        vecs[1]  = '{FReset | FRegRd, 1'b0, 32'h5,        32'h0,        1'b0, 32'h0,         1'b1, 2};
        vecs[2]  = '{7'd0,            1'b0, 32'h0,        32'h0,        1'b0, 32'h0,         1'b1, 2};
        vecs[3]  = '{FResume,         1'b0, 32'h0,        32'h0,        1'b1, 32'h0,         1'b0, 2};
        vecs[4]  = '{FPause,          1'b0, 32'h0,        32'h0,        1'b1, Pc,            1'b0, 6};
        vecs[5]  = '{FRegWr,          1'b0, 32'h5,        32'hDEADBEEF, 1'b0, 32'h0,         1'b0, 2};
        vecs[6]  = '{FRegRd,          1'b0, 32'h5,        32'h0,        1'b1, 32'hDEADBEEF,  1'b0, 2};
        vecs[7]  = '{FRegWr,          1'b0, 32'h0,        32'h1234,     1'b0, 32'h0,         1'b0, 2};
        vecs[8]  = '{FRegRd,          1'b0, 32'h0,        32'h0,        1'b1, 32'h0,         1'b0, 2};
        vecs[9]  = '{FRegRd,          1'b0, 32'h20,       32'h0,        1'b0, 32'h0,         1'b1, 2};
        vecs[10] = '{FMemWr,          1'b0, 32'h102,      32'h11111111, 1'b0, 32'h0,         1'b1, 2};
        vecs[11] = '{FMemWr,          1'b0, 32'h100,      32'hCAFEF00D, 1'b0, 32'h0,         1'b0, 2};
        vecs[12] = '{FMemRd,          1'b0, 32'h100,      32'h0,        1'b1, 32'hCAFEF00D,  1'b0, 5};
        vecs[13] = '{FMemWr,          1'b1, 32'h40,       32'h123456AB, 1'b0, 32'h0,         1'b0, 2};
        vecs[14] = '{FMemRd,          1'b1, 32'h40,       32'h0,        1'b1, 32'h000000AB,  1'b0, 5};
        vecs[15] = '{FMemWr,          1'b1, 32'h103,      32'hFFFFFF77, 1'b0, 32'h0,         1'b0, 2};
        vecs[16] = '{FMemRd,          1'b0, 32'h100,      32'h0,        1'b1, 32'h77FEF00D,  1'b0, 5};
        vecs[17] = '{FReset,          1'b0, 32'h0,        32'h0,        1'b1, 32'h77FEF00D,  1'b0, 5};
        vecs[18] = '{FResume,         1'b0, 32'h0,        32'h0,        1'b1, 32'h0,         1'b0, 2};
        vecs[19] = '{FRegRd,          1'b0, 32'h5,        32'h0,        1'b0, 32'h0,         1'b1, 2};

        for (int i = 0; i < 20; i++) begin
            do_cmd(vecs[i], i);
            if (i == 7) check("x0 rf_wd", rf_wd, 32'h1234);
            if (i == 17) begin
                check("reset pulse width", 32'(core_rst_cnt), 32'(RstCyc));
                check("halt kept over reset", {31'd0, core_halt}, 32'd1);
            end
            if (i == 18) check("halt after resume", {31'd0, core_halt}, 32'd0);
        end
        check("rf_we count", 32'(rf_we_cnt), 32'd1);
        check("mem_we count", 32'(mem_we_cnt), 32'd3);

        // Pause with the core never draining: times out and drops the halt request.
        stuck = 1'b1;
        tv = '{FPause, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, int'(HaltTo) + 2};
        do_cmd(tv, 100);
        check("halt after timeout", {31'd0, core_halt}, 32'd0);
        stuck = 1'b0;

        // rst_n pulsed while a read sits in MEM_WAIT.
        tv = '{FPause, 1'b0, 32'h0, 32'h0, 1'b1, Pc, 1'b0, 6};
        do_cmd(tv, 101);
        we_before = mem_we_cnt;
        @(posedge clk); #1;
        drive(FMemRd, 1'b0, 32'h100, 32'h0, 1'b1);
        @(posedge clk); #1;
        drive(7'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        check("mem_re in cycle 1", {31'd0, mem_re}, 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_reset_vals("rst_after");
        check("no write after reset", 32'(mem_we_cnt), 32'(we_before));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
